vec_fxp_to_fp: RTL and testbench

Sequential vector converter: signed fixed-point products or sums back to packed sign/exponent/mantissa floating-point. Accepts one vector of `length` fixed-point elements per valid/ready transaction. Converts them serially, one element per cycle, with round-to-nearest-even and saturation. Returns the packed FP vector through a second valid/ready handshake. It is the encode end of the datapath fed by `vec_mul_fp`: its input width matches that block's product width.

---
 rtl/fxp_fp_pkg.sv | 31 +++
 rtl/fxp_to_fp_elem.sv | 82 ++++++++
 rtl/vec_fxp_to_fp.sv | 97 +++++++++
 tb/tb_vec_fxp_to_fp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_fp_pkg.sv
// Shared definitions for the fixed-point <-> floating-point converters:
// FSM state type, exponent helpers and a leading-one detector.
package fxp_fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  localparam int unsigned LOD_MAX_W = 256;

  function automatic int fp_bias(input int unsigned ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_max_exp(input int unsigned ew);
    return (1 << ew) - 2;
  endfunction

  // Position of the most significant set bit; 0 when v is zero.
  function automatic int unsigned lod(input logic [LOD_MAX_W-1:0] v);
    int unsigned pos;
    pos = 0;
    for (int unsigned i = 0; i < LOD_MAX_W; i++) begin
      if (v[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/fxp_to_fp_elem.sv
// Combinational scalar converter: signed fixed point to packed FP with RNE
// rounding and saturation. Subnormal output enabled by VEC_FXP_TO_FP_SUBNORM_EN.
module fxp_to_fp_elem #(
  parameter int exp_width  = 5,
  parameter int man_width  = 2,
  parameter int bit_width  = 1 + exp_width + man_width,
  parameter int prd_width  = 2 * ((1 << exp_width) + man_width),
  parameter int frac_width = prd_width / 2
) (
  input  logic signed [prd_width-1:0] fxp_i,
  output logic        [bit_width-1:0] fp_o,
  output logic                        sat_o
);
  import fxp_fp_pkg::*;

  localparam int BIAS    = fp_bias(exp_width);
  localparam int MAX_EXP = fp_max_exp(exp_width);

  logic                 sign;
  logic [prd_width-1:0] mag;
  logic [prd_width-1:0] norm;
  int unsigned          p;
  int                   be;
  int                   be_r;
  logic [man_width-1:0] man;
  logic                 guard;
  logic                 sticky;
  logic                 rnd;
  logic [man_width:0]   man_r;

`ifdef VEC_FXP_TO_FP_SUBNORM_EN
  // Subnormal LSB weight is a fixed power of two, so the scaling is a constant select.
  localparam int SUB_SHIFT = frac_width + 1 - BIAS - man_width;

  logic [man_width-1:0] sub_m;
  logic                 sub_g;
  logic                 sub_s;
  logic                 sub_rnd;
  logic [man_width:0]   sub_r;

  assign sub_m   = mag[SUB_SHIFT +: man_width];
  assign sub_g   = mag[SUB_SHIFT-1];
  assign sub_s   = |mag[SUB_SHIFT-2:0];
  assign sub_rnd = sub_g & (sub_s | sub_m[0]);
  assign sub_r   = {1'b0, sub_m} + {{man_width{1'b0}}, sub_rnd};
`endif

  always_comb begin
    sign   = fxp_i[prd_width-1];
    mag    = sign ? ('0 - $unsigned(fxp_i)) : $unsigned(fxp_i);
    p      = lod(LOD_MAX_W'(mag));
    be     = int'(p) - frac_width + BIAS;
    // Shifting out the leading one leaves the fraction bits MSB-aligned.
    norm   = mag << (prd_width - p);
    man    = norm[prd_width-1 -: man_width];
    guard  = norm[prd_width-1-man_width];
    sticky = |norm[prd_width-2-man_width:0];
    rnd    = guard & (sticky | man[0]);
    man_r  = {1'b0, man} + {{man_width{1'b0}}, rnd};
    be_r   = be + (man_r[man_width] ? 1 : 0);

    fp_o  = '0;
    sat_o = 1'b0;
    if (mag == '0) begin
      fp_o = '0;
    end else if (be >= 1) begin
      if (be_r > MAX_EXP) begin
        fp_o  = {sign, exp_width'(MAX_EXP), {man_width{1'b1}}};
        sat_o = 1'b1;
      end else begin
        fp_o = {sign, exp_width'(be_r), man_r[man_width-1:0]};
      end
    end else begin
`ifdef VEC_FXP_TO_FP_SUBNORM_EN
      fp_o = {sign, (exp_width + man_width)'(sub_r)};
`else
      fp_o = '0;
`endif
    end
  end

endmodule

// File: rtl/vec_fxp_to_fp.sv
// Serial vector converter: fixed-point vector in, packed FP vector out, one
// element per cycle. Subnormal support via VEC_FXP_TO_FP_SUBNORM_EN.
module vec_fxp_to_fp #(
  parameter int exp_width  = 5,
  parameter int man_width  = 2,
  parameter int length     = 32,
  parameter int bit_width  = 1 + exp_width + man_width,
  parameter int prd_width  = 2 * ((1 << exp_width) + man_width),
  parameter int frac_width = prd_width / 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [prd_width-1:0] i_vec [length],
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic        [bit_width-1:0] o_vec [length],
  output logic                        o_ovf
);
  import fxp_fp_pkg::*;

  localparam int IDX_W = (length > 1) ? $clog2(length) : 1;

  state_e                       state_q;
  logic signed [prd_width-1:0]  vec_in_q  [length];
  logic        [bit_width-1:0]  vec_out_q [length];
  logic        [IDX_W-1:0]      idx_q;
  logic                         ovf_q;
  logic                         ready_q;
  logic                         valid_q;

  logic        [bit_width-1:0]  elem_fp;
  logic                         elem_sat;

  fxp_to_fp_elem #(
    .exp_width (exp_width),
    .man_width (man_width),
    .bit_width (bit_width),
    .prd_width (prd_width),
    .frac_width(frac_width)
  ) u_elem (
    .fxp_i(vec_in_q[idx_q]),
    .fp_o (elem_fp),
    .sat_o(elem_sat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < length; i++) begin
        vec_in_q[i]  <= '0;
        vec_out_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            vec_in_q <= i_vec;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= CONV;
          end
        end
        CONV: begin
          vec_out_q[idx_q] <= elem_fp;
          ovf_q            <= ovf_q | elem_sat;
          if (idx_q == IDX_W'(length - 1)) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_vec   = vec_out_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_vec_fxp_to_fp.sv
// Scoreboard bench for vec_fxp_to_fp (E5M2 defaults); model honours
// VEC_FXP_TO_FP_SUBNORM_EN the same way the design build does.
module tb_vec_fxp_to_fp;

  localparam int EW   = 5;
  localparam int MW   = 2;
  localparam int LEN  = 32;
  localparam int BW   = 1 + EW + MW;
  localparam int PW   = 2 * ((1 << EW) + MW);
  localparam int FW   = PW / 2;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int MAXE = (1 << EW) - 2;

  typedef logic [LEN*BW-1:0] pvec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 dut_ready;
  logic signed [PW-1:0] vec_in [LEN];
  logic                 dut_valid;
  logic                 out_ready = 1'b1;
  logic        [BW-1:0] vec_out [LEN];
  logic                 dut_ovf;

  logic signed [PW-1:0] stim [LEN];
  pvec_t                exp_q [$];
  bit                   ovf_exp_q [$];
  pvec_t                last_exp;
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   out_cnt = 0;

  vec_fxp_to_fp #(
    .exp_width(EW),
    .man_width(MW),
    .length   (LEN)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(in_valid),
    .o_ready(dut_ready),
    .i_vec  (vec_in),
    .o_valid(dut_valid),
    .i_ready(out_ready),
    .o_vec  (vec_out),
    .o_ovf  (dut_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic pvec_t pack_dut();
    pvec_t r;
    for (int i = 0; i < LEN; i++) r[i*BW +: BW] = vec_out[i];
    return r;
  endfunction

  // Reference: value = mag * 2^-FW, quantise to the step of its binade, RNE.
  function automatic void ref_conv(input logic signed [PW-1:0] x,
                                   output logic [BW-1:0] fp, output bit sat);
    logic [PW-1:0] mag, q, n, rem, one;
    bit neg;
    int e, qb, nn, biased;
    sat = 1'b0;
    fp  = '0;
    neg = x[PW-1];
    mag = x;
    if (neg) mag = '0 - mag;
    if (mag == '0) return;
    e = -FW;
    while ((mag >> (e + FW + 1)) != 0) e++;
    if (e + BIAS >= 1) qb = e - MW + FW;
    else begin
`ifdef VEC_FXP_TO_FP_SUBNORM_EN
      qb = 1 - BIAS - MW + FW;
`else
      return;
`endif
    end
    one = 1;
    q   = one << qb;
    n   = mag / q;
    rem = mag % q;
    if ((rem * 2 > q) || ((rem * 2 == q) && n[0])) n = n + 1;
    nn = int'(n);
    if (e + BIAS >= 1) begin
      if (nn == (1 << (MW + 1))) begin
        e++;
        nn = 1 << MW;
      end
      biased = e + BIAS;
      if (biased > MAXE) begin
        fp  = {neg, EW'(MAXE), {MW{1'b1}}};
        sat = 1'b1;
      end else begin
        fp = {neg, EW'(biased), MW'(nn - (1 << MW))};
      end
    end else begin
      if (nn == (1 << MW)) fp = {neg, EW'(1), {MW{1'b0}}};
      else fp = {neg, {EW{1'b0}}, MW'(nn)};
    end
  endfunction

  function automatic logic signed [PW-1:0] rnd_fx(input int unsigned maxbits);
    logic [95:0] r;
    logic [PW-1:0] m, one;
    int unsigned nb;
    r   = {$urandom, $urandom, $urandom};
    nb  = $urandom_range(maxbits, 1);
    one = 1;
    m   = r[PW-1:0] & ((one << nb) - 1);
    if ($urandom_range(1, 0) == 1) m = '0 - m;
    return m;
  endfunction

  task automatic fill_rand(input int unsigned maxbits);
    for (int i = 0; i < LEN; i++) stim[i] = rnd_fx(maxbits);
  endtask

  task automatic fill_directed();
    logic signed [PW-1:0] one;
    fill_rand(48);
    one = 1;
    stim[0]  = one << 34;
    stim[1]  = 5 * (one << 32);
    stim[2]  = -(3 * (one << 34));
    stim[3]  = '0;
    stim[4]  = 9 * (one << 31);
    stim[5]  = 11 * (one << 31);
    stim[6]  = one << 18;
    stim[7]  = -(one << 18);
    stim[8]  = one << 17;
    stim[9]  = 3 * (one << 17);
    stim[10] = (one << 20) - 1;
    stim[11] = -(one << 17);
  endtask

  task automatic send(input bit track, output time t_acc);
    pvec_t e;
    logic [BW-1:0] f;
    bit s, ov;
    int waited;
    ov = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      ref_conv(stim[i], f, s);
      e[i*BW +: BW] = f;
      ov |= s;
    end
    if (track) begin
      exp_q.push_back(e);
      ovf_exp_q.push_back(ov);
    end
    last_exp = e;
    waited = 0;
    @(negedge clk);
    while (!dut_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {255'b0, dut_ready}, 256'd1);
    vec_in   = stim;
    in_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 256'(exp_q.size()), 256'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && dut_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: o_valid=1 with no vector pending");
      end else begin
        pvec_t e, g;
        bit ov;
        e  = exp_q.pop_front();
        ov = ovf_exp_q.pop_front();
        g  = pack_dut();
        for (int i = 0; i < LEN; i++)
          check($sformatf("vec%0d_elem%0d", out_cnt, i), 256'(g[i*BW +: BW]), 256'(e[i*BW +: BW]));
        check($sformatf("vec%0d_ovf", out_cnt), {255'b0, dut_ovf}, {255'b0, ov});
        out_cnt++;
      end
    end
  end

  initial begin
    time t0, t1, t2, t3;
    int k;
    logic signed [PW-1:0] one;
    for (int i = 0; i < LEN; i++) vec_in[i] = '0;
    one = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {255'b0, dut_ready}, 256'd1);
    check("rst_valid", {255'b0, dut_valid}, 256'd0);
    check("rst_ovf", {255'b0, dut_ovf}, 256'd0);
    check("rst_vec", pack_dut(), '0);
    rst_n = 1'b1;

    // Saturating vector: large positive, most negative, plus random full range.
    fill_rand(67);
    stim[0] = one << 54;
    stim[1] = '0;
    stim[1][PW-1] = 1'b1;
    stim[2] = one << 34;
    send(1'b1, t0);

    fill_directed();
    send(1'b1, t0);

    for (int v = 0; v < 6; v++) begin
      fill_rand((v % 2 == 0) ? 67 : 48);
      send(1'b1, t0);
    end

    drain();
    @(posedge clk);
    #1 out_ready = 1'b0;
    fill_rand(60);
    send(1'b1, t0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dut_valid && k < 100);
    check("valid_latency", 256'(k), 256'(LEN + 1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_vec", pack_dut(), last_exp);
      check("hold_ready", {255'b0, dut_ready}, 256'd0);
      check("hold_valid", {255'b0, dut_valid}, 256'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    fill_rand(67);
    send(1'b1, t1);
    fill_rand(50);
    send(1'b1, t2);
    fill_directed();
    send(1'b1, t3);
    check("b2b_period_a", 256'((t2 - t1) / 10), 256'(LEN + 2));
    check("b2b_period_b", 256'((t3 - t2) / 10), 256'(LEN + 2));

    fill_rand(67);
    send(1'b0, t0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {255'b0, dut_ready}, 256'd1);
    check("midrst_valid", {255'b0, dut_valid}, 256'd0);
    check("midrst_ovf", {255'b0, dut_ovf}, 256'd0);
    check("midrst_vec", pack_dut(), '0);
    rst_n = 1'b1;

    fill_directed();
    send(1'b1, t0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
